// File: rtl/controle_genius_param.sv
// Sequence-game control FSM with its own round/address counters and shared LED/timeout timer; one clock per transition.
// Play timeout in espera_jogada exists only when GENIUS_TIMEOUT_EN is defined; otherwise the FSM waits for a play indefinitely.
module controle_genius_param #(
   parameter int N_JOGADAS = 16,
   parameter int ADDR_W    = 4,
   parameter int TIMER_W   = 16,
   parameter int T_LED_ON  = 1000,
   parameter int T_LED_OFF = 500,
   parameter int T_TIMEOUT = 5000
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_iniciar,
   input  logic              i_nivel,
   input  logic              i_tem_jogada,
   input  logic              i_jogadaIgualMemoria,
   output logic [ADDR_W-1:0] o_endereco,
   output logic [ADDR_W-1:0] o_sequencia,
   output logic              o_leds_en,
   output logic              o_zeraR,
   output logic              o_registraR,
   output logic              o_estado_espera,
   output logic              o_acertou,
   output logic              o_errou,
   output logic              o_pronto,
   output logic              o_db_timeout,
   output logic [3:0]        o_db_estado
);

   typedef enum logic [3:0] {
      S_INICIAL      = 4'h0,
      S_PREPARACAO   = 4'h1,
      S_LEDS_ON      = 4'h2,
      S_LEDS_OFF     = 4'h3,
      S_PROXIMO_LED  = 4'h4,
      S_ESPERA       = 4'h5,
      S_REGISTRA     = 4'h6,
      S_COMPARACAO   = 4'h7,
      S_PROXIMO      = 4'h8,
      S_PROX_SEQ     = 4'h9,
      S_FINAL_ACERTO = 4'hA,
      S_FINAL_ERRO   = 4'hE
   } state_t;

   localparam logic [TIMER_W-1:0] LP_LED_ON_END  = TIMER_W'(T_LED_ON - 1);
   localparam logic [TIMER_W-1:0] LP_LED_OFF_END = TIMER_W'(T_LED_OFF - 1);
   localparam logic [ADDR_W-1:0]  LP_LIM_FULL    = ADDR_W'(N_JOGADAS - 1);
   localparam logic [ADDR_W-1:0]  LP_LIM_HALF    = ADDR_W'(N_JOGADAS / 2 - 1);
`ifdef GENIUS_TIMEOUT_EN
   localparam logic [TIMER_W-1:0] LP_TIMEOUT_END = TIMER_W'(T_TIMEOUT - 1);
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (T_TIMEOUT != 0);
`endif

   state_t              r_state;
   logic [ADDR_W-1:0]   r_endereco;
   logic [ADDR_W-1:0]   r_sequencia;
   logic [ADDR_W-1:0]   r_limite;
   logic [TIMER_W-1:0]  r_timer;
   logic                r_db_timeout;
   logic                w_fim_seq;

   assign w_fim_seq = (r_endereco == r_sequencia);

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state      <= S_INICIAL;
         r_endereco   <= '0;
         r_sequencia  <= '0;
         r_limite     <= LP_LIM_FULL;
         r_timer      <= '0;
         r_db_timeout <= 1'b0;
      end else begin
         case (r_state)
            S_INICIAL:
               if (i_iniciar) r_state <= S_PREPARACAO;
            S_PREPARACAO: begin
               r_endereco   <= '0;
               r_sequencia  <= '0;
               r_timer      <= '0;
               r_db_timeout <= 1'b0;
               r_limite     <= i_nivel ? LP_LIM_FULL : LP_LIM_HALF;
               r_state      <= S_LEDS_ON;
            end
            S_LEDS_ON:
               if (r_timer == LP_LED_ON_END) begin
                  r_timer <= '0;
                  r_state <= S_LEDS_OFF;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            S_LEDS_OFF:
               if (r_timer == LP_LED_OFF_END) begin
                  r_timer <= '0;
                  if (w_fim_seq) begin
                     r_endereco <= '0;
                     r_state    <= S_ESPERA;
                  end else begin
                     r_state    <= S_PROXIMO_LED;
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            S_PROXIMO_LED: begin
               if (!w_fim_seq) r_endereco <= r_endereco + 1'b1;
               r_timer <= '0;
               r_state <= S_LEDS_ON;
            end
            // A play arriving on the last timeout cycle still counts.
            S_ESPERA:
               if (i_tem_jogada) r_state <= S_REGISTRA;
`ifdef GENIUS_TIMEOUT_EN
               else if (r_timer == LP_TIMEOUT_END) begin
                  r_db_timeout <= 1'b1;
                  r_state      <= S_FINAL_ERRO;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
`endif
            S_REGISTRA:
               r_state <= S_COMPARACAO;
            S_COMPARACAO:
               if (!i_jogadaIgualMemoria)        r_state <= S_FINAL_ERRO;
               else if (!w_fim_seq)              r_state <= S_PROXIMO;
               else if (r_sequencia == r_limite) r_state <= S_FINAL_ACERTO;
               else                              r_state <= S_PROX_SEQ;
            S_PROXIMO: begin
               if (!w_fim_seq) r_endereco <= r_endereco + 1'b1;
               r_timer <= '0;
               r_state <= S_ESPERA;
            end
            S_PROX_SEQ: begin
               if (r_sequencia != r_limite) r_sequencia <= r_sequencia + 1'b1;
               r_endereco <= '0;
               r_timer    <= '0;
               r_state    <= S_LEDS_ON;
            end
            S_FINAL_ACERTO, S_FINAL_ERRO:
               if (i_iniciar) r_state <= S_PREPARACAO;
            default:
               r_state <= S_INICIAL;
         endcase
      end
   end

   assign o_endereco      = r_endereco;
   assign o_sequencia     = r_sequencia;
   assign o_leds_en       = (r_state == S_LEDS_ON);
   assign o_zeraR         = (r_state == S_INICIAL) || (r_state == S_PREPARACAO);
   assign o_registraR     = (r_state == S_REGISTRA);
   assign o_estado_espera = (r_state == S_ESPERA);
   assign o_acertou       = (r_state == S_FINAL_ACERTO);
   assign o_errou         = (r_state == S_FINAL_ERRO);
   assign o_pronto        = (r_state == S_FINAL_ACERTO) || (r_state == S_FINAL_ERRO);
   assign o_db_timeout    = r_db_timeout;
   assign o_db_estado     = r_state;

endmodule

// File: tb/tb_controle_genius_param.sv
// Directed bench for controle_genius_param with a 4-item game, 3-cycle LED on, 2-cycle LED off, 10-cycle timeout.
module tb_controle_genius_param;

   logic       clk = 1'b0;
   logic       rst_n, iniciar, nivel, tem_jogada, igual;
   logic [1:0] endereco, sequencia;
   logic       leds_en, zeraR, registraR, estado_espera, acertou, errou, pronto, db_timeout;
   logic [3:0] db_estado;
   int         n_checks = 0;
   int         n_fail   = 0;

   always #5 clk = ~clk;

   controle_genius_param #(
      .N_JOGADAS(4), .ADDR_W(2), .TIMER_W(16),
      .T_LED_ON(3), .T_LED_OFF(2), .T_TIMEOUT(10)
   ) dut (
      .i_clock(clk), .i_reset(rst_n), .i_iniciar(iniciar), .i_nivel(nivel),
      .i_tem_jogada(tem_jogada), .i_jogadaIgualMemoria(igual),
      .o_endereco(endereco), .o_sequencia(sequencia), .o_leds_en(leds_en),
      .o_zeraR(zeraR), .o_registraR(registraR), .o_estado_espera(estado_espera),
      .o_acertou(acertou), .o_errou(errou), .o_pronto(pronto),
      .o_db_timeout(db_timeout), .o_db_estado(db_estado)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Runs from the state just before leds_on until espera_jogada is reached for round r.
   task automatic run_leds(input int r);
      int   cyc = 0;
      int   on = 0;
      int   items = 0;
      int   addr_err = 0;
      logic prev = 1'b0;
      logic done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         tick();
         if (db_estado == 4'h5) begin
            done = 1'b1;
         end else begin
            cyc++;
            if (leds_en) begin
               on++;
               if (!prev) items++;
               if (endereco != 2'(items - 1)) addr_err++;
            end
            prev = leds_en;
         end
      end
      chk_eq("led_reach_espera", done, 1);
      chk_eq("led_phase_cycles", cyc, 6 * r - 1);
      chk_eq("led_on_cycles", on, 3 * r);
      chk_eq("led_items", items, r);
      chk_eq("led_addr_order", addr_err, 0);
      chk_eq("led_sequencia", sequencia, r - 1);
      chk_eq("espera_addr0", endereco, 0);
   endtask

   task automatic play_round(input int r, input int wrong_at, input logic last);
      for (int k = 0; k < r; k++) begin
         chk_eq("play_in_espera", {db_estado, estado_espera}, {4'h5, 1'b1});
         tem_jogada = 1'b1;
         igual      = (k != wrong_at);
         tick();
         tem_jogada = 1'b0;
         chk_eq("registra", {db_estado, registraR}, {4'h6, 1'b1});
         tick();
         chk_eq("comparacao", db_estado, 4'h7);
         tick();
         igual = 1'b0;
         if (k == wrong_at) begin
            chk_eq("erro_state", db_estado, 4'hE);
            return;
         end
         if (k < r - 1) begin
            chk_eq("proximo", db_estado, 4'h8);
            tick();
            chk_eq("proximo_addr", endereco, k + 1);
         end else begin
            chk_eq("round_end", db_estado, last ? 4'hA : 4'h9);
         end
      end
   endtask

   task automatic start_game(input logic nv);
      iniciar = 1'b1;
      nivel   = nv;
      tick();
      iniciar = 1'b0;
      chk_eq("preparacao", {db_estado, zeraR}, {4'h1, 1'b1});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1);
   end

   initial begin
      int n;
      rst_n = 1'b1; iniciar = 1'b0; nivel = 1'b0; tem_jogada = 1'b0; igual = 1'b0;
      #2 rst_n = 1'b0;
      tick();
      tick();
      chk_eq("rst_estado", db_estado, 4'h0);
      chk_eq("rst_zeraR", zeraR, 1);
      chk_eq("rst_flags", {leds_en, registraR, estado_espera, acertou, errou, pronto, db_timeout}, 7'b0);
      chk_eq("rst_counters", {endereco, sequencia}, 4'h0);
      rst_n = 1'b1;
      tick();
      chk_eq("inicial_idle", db_estado, 4'h0);

      // Full game, 4 rounds
      start_game(1'b1);
      for (int r = 1; r <= 4; r++) begin
         run_leds(r);
         play_round(r, -1, r == 4);
      end
      chk_eq("g1_flags", {acertou, errou, pronto}, 3'b101);
      chk_eq("g1_sequencia", sequencia, 3);
      tick();
      tick();
      chk_eq("g1_hold", db_estado, 4'hA);

      // Short game, 2 rounds
      start_game(1'b0);
      for (int r = 1; r <= 2; r++) begin
         run_leds(r);
         play_round(r, -1, r == 2);
      end
      chk_eq("g2_final", {db_estado, acertou, pronto}, {4'hA, 2'b11});
      chk_eq("g2_sequencia", sequencia, 1);

      // Wrong play at address 1 of round 3, with iniciar held through round 1 LEDs
      iniciar = 1'b1;
      nivel   = 1'b1;
      tick();
      chk_eq("g3_preparacao", db_estado, 4'h1);
      run_leds(1);
      iniciar = 1'b0;
      play_round(1, -1, 1'b0);
      run_leds(2);
      play_round(2, -1, 1'b0);
      run_leds(3);
      play_round(3, 1, 1'b0);
      chk_eq("g3_flags", {acertou, errou, pronto, db_timeout}, 4'b0110);
      chk_eq("g3_estado", db_estado, 4'hE);
      chk_eq("g3_endereco", endereco, 1);

      // Reset asserted in leds_on of round 2
      start_game(1'b1);
      run_leds(1);
      play_round(1, -1, 1'b0);
      tick();
      chk_eq("r2_leds_on", {db_estado, leds_en, sequencia}, {4'h2, 1'b1, 2'd1});
      rst_n = 1'b0;
      #1;
      chk_eq("midrst_estado", db_estado, 4'h0);
      chk_eq("midrst_outs", {leds_en, zeraR, pronto, acertou, errou, sequencia, endereco}, {5'b01000, 4'h0});
      tick();
      rst_n = 1'b1;
      tick();
      chk_eq("midrst_idle", db_estado, 4'h0);
      start_game(1'b1);
      run_leds(1);

`ifdef GENIUS_TIMEOUT_EN
      n = 0;
      for (int i = 0; i < 50 && db_estado == 4'h5; i++) begin
         tick();
         n++;
      end
      chk_eq("timeout_cycles", n, 10);
      chk_eq("timeout_final", {db_estado, errou, db_timeout}, {4'hE, 2'b11});
      start_game(1'b1);
      run_leds(1);
      chk_eq("timeout_cleared", db_timeout, 0);
      repeat (9) tick();
      chk_eq("timeout_last_wait", db_estado, 4'h5);
      tem_jogada = 1'b1;
      igual      = 1'b1;
      tick();
      tem_jogada = 1'b0;
      chk_eq("play_beats_timeout", db_estado, 4'h6);
      igual = 1'b0;
`else
      n = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (db_estado == 4'h5) n++;
      end
      chk_eq("no_timeout_cycles", n, 1000);
      chk_eq("no_timeout_flags", {estado_espera, errou, db_timeout}, 3'b100);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/controle_genius_param.md
# controle_genius_param

Parametrised control unit for the sequence-memory game: owns the state machine plus the internal round counter, address counter, LED display timer and play timeout timer that earlier generations took from the datapath. It sits between the game's memory/register/comparator datapath and the board I/O. The datapath supplies the play and comparison status; this block drives the memory address, LED enable and register controls. Game length is selectable at run time.

## Interface
- N_JOGADAS, 16, maximum sequence length; power of two, ≥ 2
- ADDR_W, 4, address/round counter width; 2^ADDR_W = N_JOGADAS
- TIMER_W, 16, width of the shared cycle timer
- T_LED_ON, 1000, cycles one LED is shown
- T_LED_OFF, 500, blank cycles after each LED
- T_TIMEOUT, 5000, cycles allowed per play (only with timeout compiled in)

- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state while low
- iniciar  in  1  start/restart request, level-sampled
- nivel  in  1  sampled in preparacao: 0 = N_JOGADAS/2 rounds, 1 = N_JOGADAS rounds
- tem_jogada  in  1  one-cycle pulse, a play is present
- jogadaIgualMemoria  in  1  registered play equals memory[endereco]
- endereco  out  ADDR_W  memory read address
- sequencia  out  ADDR_W  index of last item in the current round
- leds_en  out  1  show memory[endereco] on the LEDs
- zeraR  out  1  clear the play register
- registraR  out  1  load the play register
- estado_espera  out  1  waiting for a play
- acertou / errou / pronto  out  1  final flags
- db_timeout  out  1  the last game ended by timeout
- db_estado  out  4  current state code

## Operation
- States (code): inicial 0, preparacao 1, leds_on 2, leds_off 3, proximo_led 4, espera_jogada 5, registra 6, comparacao 7, proximo 8, proxima_sequencia 9, final_acerto A, final_erro E. Any other code goes to inicial.
- inicial: iniciar → preparacao.
- preparacao:
  - endereco, sequencia, timer and db_timeout go to 0.
  - limite latches nivel ? N_JOGADAS−1 : N_JOGADAS/2−1.
  - Next state is leds_on.
- leds_on: leds_en=1. When timer = T_LED_ON−1 → leds_off, timer←0.
- leds_off: when timer = T_LED_OFF−1:
  - endereco = sequencia → espera_jogada, endereco←0, timer←0.
  - Otherwise → proximo_led.
- proximo_led: endereco+1, timer←0 → leds_on.
- espera_jogada:
  - tem_jogada → registra.
  - Otherwise timer = T_TIMEOUT−1 → final_erro with db_timeout←1.
  - tem_jogada wins when both occur in the same cycle.
- registra: registraR=1 → comparacao.
- comparacao:
  - Mismatch → final_erro.
  - Match and endereco ≠ sequencia → proximo.
  - Match and endereco = sequencia and sequencia = limite → final_acerto.
  - Match and endereco = sequencia, otherwise → proxima_sequencia.
- proximo: endereco+1, timer←0 → espera_jogada.
- proxima_sequencia: sequencia+1, endereco←0, timer←0 → leds_on.
- final_acerto / final_erro: hold; iniciar → preparacao.
- Moore outputs decoded from the state:
  - zeraR in inicial and preparacao.
  - pronto in both finals; acertou and errou in their own final.
  - estado_espera in espera_jogada.
- Counters never wrap. sequencia is bounded by limite and endereco by sequencia.

## Timing
- Reset (reset low): state inicial, endereco=0, sequencia=0, timer=0, limite=N_JOGADAS−1, db_timeout=0. All outputs read 0 except zeraR=1; db_estado=0.
- Reset mid-game aborts immediately with no completion flag.
- Each state transition takes one clock.
- LED phase per item: exactly T_LED_ON cycles with leds_en high, then T_LED_OFF cycles low, then 1 cycle of proximo_led between items.
- Play path: tem_jogada, then 1 cycle registra, then 1 cycle comparacao. comparacao sees jogadaIgualMemoria for the value registered in registra.
- Timeout is T_TIMEOUT cycles counted from entry into espera_jogada. The timer restarts for every play.
- iniciar held high in a final state restarts the game. iniciar in any non-final, non-inicial state is ignored.

## Configuration
- GENIUS_TIMEOUT_EN defined: espera_jogada timeout is active as described.
- GENIUS_TIMEOUT_EN undefined:
  - The timer does not run in espera_jogada.
  - espera_jogada waits indefinitely for a play.
  - db_timeout is tied to 0.
  - T_TIMEOUT is unused.

## Test plan
- N_JOGADAS=4, T_LED_ON=3, T_LED_OFF=2, nivel=1, all plays correct → rounds show 1,2,3,4 LEDs with leds_en high 3 cycles each; game ends with acertou=pronto=1, sequencia=3, db_estado=A.
- nivel=0, same setup → final_acerto after round 2 (sequencia=1).
- Wrong play (jogadaIgualMemoria=0) at endereco=1 in round 3 → final_erro, errou=1, db_timeout=0, db_estado=E.
- Timeout built in, T_TIMEOUT=10, no play → final_erro with db_timeout=1 exactly 10 cycles after entering espera_jogada. tem_jogada on cycle 10 instead → registra.
- reset pulled low during leds_on in round 2 → next cycle all outputs at reset values. After release, iniciar replays from round 1.
- Timeout compiled out, 1000 idle cycles in espera_jogada → state stays 5, errou=0.
